// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel stream in, 3x3 window with coordinates and strobes out.
interface sobel_window_gen_if #(parameter int DW = 8, parameter int CW = 12);
    logic          pix_valid;
    logic          pix_sof;
    logic [DW-1:0] pix_data;
    logic          shift_en;
    logic          pos_valid;
    logic          frame_done;
    logic [CW-1:0] a22_x;
    logic [CW-1:0] a22_y;
    logic [DW-1:0] a11, a12, a13, a21, a22, a23, a31, a32, a33;
    modport master (
        output pix_valid, pix_sof, pix_data,
        input  shift_en, pos_valid, frame_done, a22_x, a22_y,
        input  a11, a12, a13, a21, a22, a23, a31, a32, a33
    );
    modport slave (
        input  pix_valid, pix_sof, pix_data,
        output shift_en, pos_valid, frame_done, a22_x, a22_y,
        output a11, a12, a13, a21, a22, a23, a31, a32, a33
    );
endinterface

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: buffers two lines of a raster stream and emits a 3x3 window,
// its centre coordinates and a shift strobe two cycles after each accepted pixel.
module sobel_window_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 8,
    parameter int CW    = 12
) (
    input logic clk,
    input logic rst,
    sobel_window_gen_if.slave bus
);
    localparam int AW = $clog2(IMG_W);
    localparam logic [CW-1:0] X_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(IMG_H - 1);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t        state, state_n;
    logic [CW-1:0] in_x, in_y, x_cur, y_cur, x_n, y_n;
    logic          accept;
    logic          last;
    logic [AW-1:0] addr;
    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] lb0_q, lb1_q, pix_d;
    logic [CW-1:0] s1_x, s1_y;
    logic          s1_valid;
    // sof forces the pixel to (0,0) regardless of the running counters
    always_comb begin
        accept  = bus.pix_valid && (state == ACTIVE || bus.pix_sof);
        x_cur   = bus.pix_sof ? '0 : in_x;
        y_cur   = bus.pix_sof ? '0 : in_y;
        last    = x_cur == X_LAST && y_cur == Y_LAST;
        x_n     = x_cur == X_LAST ? '0 : x_cur + CW'(1);
        y_n     = x_cur != X_LAST ? y_cur : y_cur == Y_LAST ? '0 : y_cur + CW'(1);
        state_n = !accept ? state : last ? IDLE : ACTIVE;
        addr    = x_cur[AW-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_x     <= '0;
            in_y     <= '0;
            s1_valid <= 1'b0;
        end else begin
            state    <= state_n;
            s1_valid <= accept;
            if (accept) begin
                in_x <= x_n;
                in_y <= y_n;
            end
        end
    end
    // Line buffers are read-before-write; the old lb0 entry cascades into lb1
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q     <= lb1[addr];
            lb0_q     <= lb0[addr];
            lb1[addr] <= lb0[addr];
            lb0[addr] <= bus.pix_data;
            pix_d     <= bus.pix_data;
            s1_x      <= x_cur;
            s1_y      <= y_cur;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.shift_en   <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.pos_valid  <= 1'b0;
            bus.a22_x      <= '0;
            bus.a22_y      <= '0;
            {bus.a11, bus.a12, bus.a13} <= '0;
            {bus.a21, bus.a22, bus.a23} <= '0;
            {bus.a31, bus.a32, bus.a33} <= '0;
        end else begin
            bus.shift_en   <= s1_valid;
            bus.frame_done <= s1_valid && s1_x == X_LAST && s1_y == Y_LAST;
            if (s1_valid) begin
                {bus.a11, bus.a12, bus.a13} <= {bus.a12, bus.a13, lb1_q};
                {bus.a21, bus.a22, bus.a23} <= {bus.a22, bus.a23, lb0_q};
                {bus.a31, bus.a32, bus.a33} <= {bus.a32, bus.a33, pix_d};
                bus.pos_valid <= s1_x >= CW'(2) && s1_y >= CW'(2);
                bus.a22_x     <= s1_x == '0 ? '0 : s1_x - CW'(1);
                bus.a22_y     <= s1_y == '0 ? '0 : s1_y - CW'(1);
            end
        end
    end
endmodule
